// File: rtl/weight_stabilizer.sv
// Settle-and-accept stage between the load-cell driver and the display path.
// A reading is accepted once STABLE_N consecutive samples stay within +/-TOL
// of the first sample of the run; tare zeroes the scale at an accepted value.
module weight_stabilizer #(
  parameter int DATA_W   = 24,
  parameter int STABLE_N = 5,
  parameter int TOL      = 0,
  parameter int SEL_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     sample_valid,
  input  logic                     tare,
  input  logic [SEL_W-1:0]         byte_sel,
  output logic signed [DATA_W-1:0] weight_out,
  output logic                     stable,
  output logic                     new_weight,
  output logic [7:0]               match_cnt,
  output logic [7:0]               byte_out
);

  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int XW     = 8 * NBYTES;

  localparam logic signed [DATA_W:0] TOL_X = (DATA_W + 1)'(TOL);
  localparam logic [7:0]             N_X   = 8'(STABLE_N);

  // Magnitude of a - b, widened by one bit so opposite-sign extremes never wrap.
  function automatic logic signed [DATA_W:0] abs_diff(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    return (d < 0) ? -d : d;
  endfunction

  // Net weight wraps modulo 2^DATA_W, matching the raw two's-complement range.
  function automatic logic signed [DATA_W-1:0] net_wrap(
    input logic signed [DATA_W-1:0] raw,
    input logic signed [DATA_W-1:0] offset
  );
    return raw - offset;
  endfunction

  logic signed [DATA_W-1:0] sample_s;
  logic signed [DATA_W-1:0] ref_p0,      ref_n;
  logic signed [DATA_W-1:0] accepted_p0, accepted_n;
  logic signed [DATA_W-1:0] offset_p0,   offset_n;
  logic signed [DATA_W-1:0] weight_p0,   weight_n;
  logic [7:0]               cnt_p0,      cnt_n;
  logic                     stable_p0,   stable_n;
  logic                     new_p0,      new_n;
  logic                     pending_p0,  pending_n;
  logic                     in_tol;
  logic                     accept;
  logic signed [XW-1:0]     weight_x;

  assign sample_s = sample_in;
  assign in_tol   = (abs_diff(sample_s, ref_p0) <= TOL_X);

  // Next-state: run tracking first, then tare applied to the post-sample state.
  always_comb begin
    ref_n      = ref_p0;
    accepted_n = accepted_p0;
    offset_n   = offset_p0;
    weight_n   = weight_p0;
    cnt_n      = cnt_p0;
    stable_n   = stable_p0;
    pending_n  = pending_p0;
    new_n      = 1'b0;
    accept     = 1'b0;

    if (sample_valid) begin
      if ((cnt_p0 == 8'd0) || !in_tol) begin
        // New run anchored at this sample; ref stays put while the run holds.
        ref_n    = sample_s;
        cnt_n    = 8'd1;
        stable_n = 1'b0;
        accept   = (N_X == 8'd1);
      end else if (cnt_p0 < N_X) begin
        cnt_n  = cnt_p0 + 8'd1;
        accept = (cnt_n == N_X);
      end
    end

    if (accept) begin
      accepted_n = sample_s;
      stable_n   = 1'b1;
      new_n      = 1'b1;
      if (pending_p0 || tare) begin
        offset_n  = sample_s;
        weight_n  = '0;
        pending_n = 1'b0;
      end else begin
        weight_n = net_wrap(sample_s, offset_p0);
      end
    end else if (tare) begin
      if (stable_n) begin
        offset_n = accepted_p0;
        weight_n = '0;
        new_n    = 1'b1;
      end else begin
        pending_n = 1'b1;
      end
    end
  end

  // State register; reset clears every tracking and data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_p0      <= '0;
      accepted_p0 <= '0;
      offset_p0   <= '0;
      weight_p0   <= '0;
      cnt_p0      <= '0;
      stable_p0   <= 1'b0;
      new_p0      <= 1'b0;
      pending_p0  <= 1'b0;
    end else begin
      ref_p0      <= ref_n;
      accepted_p0 <= accepted_n;
      offset_p0   <= offset_n;
      weight_p0   <= weight_n;
      cnt_p0      <= cnt_n;
      stable_p0   <= stable_n;
      new_p0      <= new_n;
      pending_p0  <= pending_n;
    end
  end

  assign weight_out = weight_p0;
  assign stable     = stable_p0;
  assign new_weight = new_p0;
  assign match_cnt  = cnt_p0;

  // Sign-extend to whole bytes so a partial top byte carries the sign.
  assign weight_x = XW'(weight_p0);

  // Byte view for display drivers; out-of-range selectors read as zero.
  always_comb begin
    byte_out = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (int'(byte_sel) == i) byte_out = weight_x[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_weight_stabilizer.sv
// Directed bench for weight_stabilizer: three instances share stimulus
// (STABLE_N=5/TOL=0, STABLE_N=1/TOL=0, STABLE_N=5/TOL=2).
module tb_weight_stabilizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        tare;
  logic [1:0]  byte_sel;

  logic [23:0] w0, w1, w2;
  logic        st0, st1, st2;
  logic        nw0, nw1, nw2;
  logic [7:0]  mc0, mc1, mc2;
  logic [7:0]  bo0, bo1, bo2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  weight_stabilizer #(.DATA_W(24), .STABLE_N(5), .TOL(0), .SEL_W(2)) dut0 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .tare(tare), .byte_sel(byte_sel), .weight_out(w0), .stable(st0),
    .new_weight(nw0), .match_cnt(mc0), .byte_out(bo0));

  weight_stabilizer #(.DATA_W(24), .STABLE_N(1), .TOL(0), .SEL_W(2)) dut1 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .tare(tare), .byte_sel(byte_sel), .weight_out(w1), .stable(st1),
    .new_weight(nw1), .match_cnt(mc1), .byte_out(bo1));

  weight_stabilizer #(.DATA_W(24), .STABLE_N(5), .TOL(2), .SEL_W(2)) dut2 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .tare(tare), .byte_sel(byte_sel), .weight_out(w2), .stable(st2),
    .new_weight(nw2), .match_cnt(mc2), .byte_out(bo2));

  // One sample strobe for one clock; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [23:0] d, input logic t);
    sample_in    = d;
    sample_valid = 1'b1;
    tare         = t;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    tare         = 1'b0;
  endtask

  task automatic send_n(input logic [23:0] d, input int n);
    for (int i = 0; i < n; i++) send(d, 1'b0);
  endtask

  task automatic pulse_tare();
    tare = 1'b1;
    @(posedge clk); #1;
    tare = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0; tare = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (w2 !== 24'h0)  begin n_fail++; $display("FAIL reset_weight: got %h expected 000000", w2); end
    n_checks++; if (st2 !== 1'b0)  begin n_fail++; $display("FAIL reset_stable: got %b expected 0", st2); end
    n_checks++; if (nw2 !== 1'b0)  begin n_fail++; $display("FAIL reset_new: got %b expected 0", nw2); end
    n_checks++; if (mc2 !== 8'd0)  begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", mc2); end
    n_checks++; if (bo0 !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", bo0); end
  endtask

  task automatic test_exact();
    send(24'h001234, 1'b0);
    n_checks++; if (nw1 !== 1'b1)       begin n_fail++; $display("FAIL n1_first_pulse: got %b expected 1", nw1); end
    n_checks++; if (w1 !== 24'h001234)  begin n_fail++; $display("FAIL n1_weight: got %h expected 001234", w1); end
    send_n(24'h001234, 3);
    n_checks++; if (nw1 !== 1'b0)       begin n_fail++; $display("FAIL n1_no_repeat: got %b expected 0", nw1); end
    n_checks++; if (mc0 !== 8'd4)       begin n_fail++; $display("FAIL exact_cnt4: got %0d expected 4", mc0); end
    n_checks++; if (nw0 !== 1'b0 || st0 !== 1'b0) begin n_fail++; $display("FAIL exact_early: got new=%b stable=%b expected 0 0", nw0, st0); end
    send(24'h001234, 1'b0);
    n_checks++; if (nw0 !== 1'b1)       begin n_fail++; $display("FAIL exact_pulse: got %b expected 1", nw0); end
    n_checks++; if (w0 !== 24'h001234)  begin n_fail++; $display("FAIL exact_weight: got %h expected 001234", w0); end
    n_checks++; if (st0 !== 1'b1)       begin n_fail++; $display("FAIL exact_stable: got %b expected 1", st0); end
    n_checks++; if (mc0 !== 8'd5)       begin n_fail++; $display("FAIL exact_cnt5: got %0d expected 5", mc0); end
    idle();
    n_checks++; if (nw0 !== 1'b0)       begin n_fail++; $display("FAIL exact_pulse_width: got %b expected 0", nw0); end
    send(24'h001234, 1'b0);
    n_checks++; if (nw0 !== 1'b0 || mc0 !== 8'd5 || st0 !== 1'b1) begin n_fail++; $display("FAIL exact_sixth: got new=%b cnt=%0d stable=%b expected 0 5 1", nw0, mc0, st0); end
  endtask

  task automatic test_tolerance();
    do_reset();
    send(24'd1000, 1'b0); send(24'd1002, 1'b0); send(24'd998, 1'b0); send(24'd1001, 1'b0);
    send(24'd999, 1'b0);
    n_checks++; if (nw2 !== 1'b1 || w2 !== 24'd999) begin n_fail++; $display("FAIL tol_accept: got new=%b weight=%0d expected 1 999", nw2, w2); end
    n_checks++; if (mc0 !== 8'd1 || st0 !== 1'b0)    begin n_fail++; $display("FAIL tol0_restart: got cnt=%0d stable=%b expected 1 0", mc0, st0); end
    send(24'd1000, 1'b0);
    n_checks++; if (mc2 !== 8'd5 || st2 !== 1'b1)    begin n_fail++; $display("FAIL tol_hold: got cnt=%0d stable=%b expected 5 1", mc2, st2); end
    send(24'd1003, 1'b0);
    n_checks++; if (mc2 !== 8'd1)    begin n_fail++; $display("FAIL tol_break_cnt: got %0d expected 1", mc2); end
    n_checks++; if (st2 !== 1'b0)    begin n_fail++; $display("FAIL tol_break_stable: got %b expected 0", st2); end
    n_checks++; if (w2 !== 24'd999)  begin n_fail++; $display("FAIL tol_break_weight: got %0d expected 999", w2); end
    send(24'd1005, 1'b0);
    n_checks++; if (mc2 !== 8'd2)    begin n_fail++; $display("FAIL tol_new_ref: got %0d expected 2", mc2); end
  endtask

  task automatic test_wrap();
    do_reset();
    send(24'h7FFFFF, 1'b0);
    send(24'h800000, 1'b0);
    n_checks++; if (mc2 !== 8'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 1", mc2); end
    send(24'h800002, 1'b0);
    n_checks++; if (mc2 !== 8'd2) begin n_fail++; $display("FAIL wrap_neg_tol: got %0d expected 2", mc2); end
  endtask

  task automatic test_tare_stable();
    int pulses;
    do_reset();
    send_n(24'h000500, 5);
    n_checks++; if (w2 !== 24'h000500) begin n_fail++; $display("FAIL ts_pre_weight: got %h expected 000500", w2); end
    pulse_tare();
    n_checks++; if (w2 !== 24'h0 || nw2 !== 1'b1 || st2 !== 1'b1) begin n_fail++; $display("FAIL ts_tare: got weight=%h new=%b stable=%b expected 000000 1 1", w2, nw2, st2); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      send(24'h000400, 1'b0);
      if (nw2) pulses++;
    end
    n_checks++; if (pulses !== 1)       begin n_fail++; $display("FAIL ts_pulses: got %0d expected 1", pulses); end
    n_checks++; if (w2 !== 24'hFFFF00)  begin n_fail++; $display("FAIL ts_net: got %h expected ffff00", w2); end
    byte_sel = 2'd0; #1;
    n_checks++; if (bo2 !== 8'h00) begin n_fail++; $display("FAIL byte0: got %h expected 00", bo2); end
    byte_sel = 2'd1; #1;
    n_checks++; if (bo2 !== 8'hFF) begin n_fail++; $display("FAIL byte1: got %h expected ff", bo2); end
    byte_sel = 2'd2; #1;
    n_checks++; if (bo2 !== 8'hFF) begin n_fail++; $display("FAIL byte2: got %h expected ff", bo2); end
    byte_sel = 2'd3; #1;
    n_checks++; if (bo2 !== 8'h00) begin n_fail++; $display("FAIL byte3: got %h expected 00", bo2); end
    byte_sel = 2'd0;
  endtask

  task automatic test_tare_pending();
    int pulses;
    do_reset();
    send_n(24'h000100, 2);
    pulse_tare();
    n_checks++; if (nw2 !== 1'b0 || w2 !== 24'h0) begin n_fail++; $display("FAIL tp_no_pulse: got new=%b weight=%h expected 0 000000", nw2, w2); end
    pulse_tare();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      send(24'h000200, 1'b0);
      if (nw2) pulses++;
    end
    n_checks++; if (pulses !== 1)      begin n_fail++; $display("FAIL tp_pulses: got %0d expected 1", pulses); end
    n_checks++; if (w2 !== 24'h0)      begin n_fail++; $display("FAIL tp_zero: got %h expected 000000", w2); end
    send_n(24'h000300, 5);
    n_checks++; if (w2 !== 24'h000100) begin n_fail++; $display("FAIL tp_net: got %h expected 000100", w2); end
  endtask

  task automatic test_tare_with_sample();
    do_reset();
    send_n(24'h000050, 4);
    send(24'h000050, 1'b1);
    n_checks++; if (nw2 !== 1'b1 || w2 !== 24'h0) begin n_fail++; $display("FAIL tws_accept: got new=%b weight=%h expected 1 000000", nw2, w2); end
    send_n(24'h000060, 5);
    n_checks++; if (w2 !== 24'h000010) begin n_fail++; $display("FAIL tws_offset: got %h expected 000010", w2); end
    send(24'h000070, 1'b1);
    n_checks++; if (nw2 !== 1'b0 || st2 !== 1'b0 || w2 !== 24'h000010) begin n_fail++; $display("FAIL tws_break: got new=%b stable=%b weight=%h expected 0 0 000010", nw2, st2, w2); end
    send_n(24'h000070, 4);
    n_checks++; if (nw2 !== 1'b1 || w2 !== 24'h0) begin n_fail++; $display("FAIL tws_pending: got new=%b weight=%h expected 1 000000", nw2, w2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_n(24'h000020, 3);
    pulse_tare();
    n_checks++; if (mc2 !== 8'd3) begin n_fail++; $display("FAIL rm_cnt3: got %0d expected 3", mc2); end
    reset = 1'b1; sample_in = 24'h000020; sample_valid = 1'b1; tare = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; sample_valid = 1'b0; tare = 1'b0;
    n_checks++; if (mc2 !== 8'd0 || st2 !== 1'b0 || nw2 !== 1'b0 || w2 !== 24'h0) begin n_fail++; $display("FAIL rm_clear: got cnt=%0d stable=%b new=%b weight=%h expected 0 0 0 000000", mc2, st2, nw2, w2); end
    send_n(24'h000010, 5);
    n_checks++; if (w2 !== 24'h000010 || nw2 !== 1'b1) begin n_fail++; $display("FAIL rm_after: got weight=%h new=%b expected 000010 1", w2, nw2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sample_in = 24'h000077; sample_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (mc2 !== 8'(i)) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected %0d", mc2, i); end
    end
    n_checks++; if (nw2 !== 1'b1 || w2 !== 24'h000077) begin n_fail++; $display("FAIL b2b_accept: got new=%b weight=%h expected 1 000077", nw2, w2); end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    n_checks++; if (nw2 !== 1'b0) begin n_fail++; $display("FAIL b2b_single: got %b expected 0", nw2); end
  endtask

  initial begin
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0; tare = 1'b0; byte_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_exact();
    test_tolerance();
    test_wrap();
    test_tare_stable();
    test_tare_pending();
    test_tare_with_sample();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
